ex_stage: RTL and testbench

Execute stage of the 5-stage in-order pipeline. It sits directly upstream of the memory stage. It latches decoded operands from the decode stage and computes ALU results or an iterative 32-bit divide. It also forms the byte-lane store controls and presents the memory stage's input bundle under the valid/allow_in handshake.

---
 rtl/cpu_defs.sv | 44 ++++
 rtl/div_radix2.sv | 102 ++++++++++
 rtl/ex_stage.sv | 147 ++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared pipeline definitions for the execute stage
// Purpose: ALU one-hot bit positions, divide-op bit positions, store type
//          codes, divider state encoding, reset PC and an operand helper.
// Ports:   none (package).
package cpu_defs;

   // Bit positions inside the 12-bit one-hot alu_op vector
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   // Bit positions inside the 3-bit div_op vector {en, signed, rem}
   localparam int DIV_EN     = 2;
   localparam int DIV_SIGNED = 1;
   localparam int DIV_REM    = 0;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_BYTE = 2'b01;
   localparam logic [1:0] ST_HALF = 2'b10;
   localparam logic [1:0] ST_WORD = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;

   // Magnitude of a 32-bit operand; -2^31 maps onto 0x80000000 unsigned
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative restoring radix-2 32-bit divider
// Purpose: one shift-subtract step per cycle over 32 cycles, then holds the
//          sign-corrected result in DONE until the consumer acknowledges.
// Ports:   clk, reset (async active-low), start, is_signed, dividend,
//          divisor, ack (leave DONE), busy (not IDLE), done (in DONE),
//          quotient, remainder.
module div_radix2
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        ack,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   div_state_t  state;
   div_state_t  next_state;
   logic [4:0]  count;
   logic [31:0] quo_r;
   logic [31:0] rem_r;
   logic [31:0] dvs_r;
   logic [31:0] raw_dividend;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;

   logic [32:0] rem_shift;
   logic [32:0] trial;

   // Bring the next dividend bit into the partial remainder and try a subtract
   assign rem_shift = {rem_r, quo_r[31]};
   assign trial     = rem_shift - {1'b0, dvs_r};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= DIV_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         DIV_IDLE: if (start)          next_state = DIV_CALC;
         DIV_CALC: if (count == 5'd0)  next_state = DIV_DONE;
         DIV_DONE: if (ack)            next_state = DIV_IDLE;
         default:                      next_state = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count        <= 5'd0;
         quo_r        <= 32'd0;
         rem_r        <= 32'd0;
         dvs_r        <= 32'd0;
         raw_dividend <= 32'd0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div_zero     <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  quo_r        <= abs32(dividend, is_signed);
                  dvs_r        <= abs32(divisor, is_signed);
                  rem_r        <= 32'd0;
                  raw_dividend <= dividend;
                  neg_q        <= is_signed && (dividend[31] ^ divisor[31]);
                  neg_r        <= is_signed && dividend[31];
                  div_zero     <= (divisor == 32'd0);
                  count        <= 5'd31;
               end
            end
            DIV_CALC: begin
               // trial[32] set means the subtract borrowed: restore
               if (!trial[32]) begin
                  rem_r <= trial[31:0];
                  quo_r <= {quo_r[30:0], 1'b1};
               end else begin
                  rem_r <= rem_shift[31:0];
                  quo_r <= {quo_r[30:0], 1'b0};
               end
               if (count != 5'd0) count <= count - 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != DIV_IDLE);
   assign done      = (state == DIV_DONE);
   // Divide by zero bypasses sign correction entirely
   assign quotient  = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo_r + 32'd1) : quo_r);
   assign remainder = div_zero ? raw_dividend  : (neg_r ? (~rem_r + 32'd1) : rem_r);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage of the 5-stage in-order pipeline
// Purpose: latches decoded operands, computes ALU or divide results, forms
//          store byte enables/data and hands the bundle to the memory stage.
// Ports:   clk, reset (async active-low); handshake ds_to_es_valid,
//          es_allow_in, ms_allow_in, es_to_ms_valid; decode inputs ds_*;
//          outputs es_pc, es_data_sram_*, es_rf_*, es_valid, es_div_busy.
module ex_stage
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_to_es_valid,
   output logic        es_allow_in,
   input  logic        ms_allow_in,
   output logic        es_to_ms_valid,
   input  logic [31:0] ds_pc,
   input  logic [11:0] ds_alu_op,
   input  logic [2:0]  ds_div_op,
   input  logic [31:0] ds_src1,
   input  logic [31:0] ds_src2,
   input  logic [1:0]  ds_st_type,
   input  logic [31:0] ds_st_data,
   input  logic        ds_gr_we,
   input  logic [4:0]  ds_dest,
   output logic [31:0] es_pc,
   output logic [3:0]  es_data_sram_we,
   output logic [31:0] es_data_sram_addr,
   output logic [31:0] es_data_sram_wdata,
   output logic [3:0]  es_rf_we,
   output logic [4:0]  es_rf_waddr,
   output logic [31:0] es_rf_wdata,
   output logic        es_valid,
   output logic        es_div_busy
);

   logic [11:0] alu_op;
   logic [2:0]  div_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [1:0]  st_type;
   logic [31:0] st_data;
   logic        gr_we;
   logic [4:0]  dest;

   logic        es_ready_go;
   logic        div_done;
   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic [31:0] sum;
   logic [31:0] alu_result;
   logic [3:0]  st_we;
   logic [31:0] st_wdata;
   logic [4:0]  sh;

   assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
   assign es_to_ms_valid = es_valid && es_ready_go;
   assign es_ready_go    = div_op[DIV_EN] ? div_done : 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           es_valid <= 1'b0;
      else if (es_allow_in) es_valid <= ds_to_es_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         es_pc   <= RESET_PC;
         alu_op  <= 12'd0;
         div_op  <= 3'd0;
         src1    <= 32'd0;
         src2    <= 32'd0;
         st_type <= ST_NONE;
         st_data <= 32'd0;
         gr_we   <= 1'b0;
         dest    <= 5'd0;
      end else if (es_allow_in && ds_to_es_valid) begin
         es_pc   <= ds_pc;
         alu_op  <= ds_alu_op;
         div_op  <= ds_div_op;
         src1    <= ds_src1;
         src2    <= ds_src2;
         st_type <= ds_st_type;
         st_data <= ds_st_data;
         gr_we   <= ds_gr_we;
         dest    <= ds_dest;
      end
   end

   assign sum = src1 + src2;
   assign sh  = src2[4:0];

   // alu_op is one-hot, so the OR-combine selects exactly one result
   always_comb begin
      alu_result = 32'd0;
      if (alu_op[ALU_ADD])  alu_result = alu_result | sum;
      if (alu_op[ALU_SUB])  alu_result = alu_result | (src1 - src2);
      if (alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, ($signed(src1) < $signed(src2))};
      if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, (src1 < src2)};
      if (alu_op[ALU_AND])  alu_result = alu_result | (src1 & src2);
      if (alu_op[ALU_NOR])  alu_result = alu_result | ~(src1 | src2);
      if (alu_op[ALU_OR])   alu_result = alu_result | (src1 | src2);
      if (alu_op[ALU_XOR])  alu_result = alu_result | (src1 ^ src2);
      if (alu_op[ALU_SLL])  alu_result = alu_result | (src1 << sh);
      if (alu_op[ALU_SRL])  alu_result = alu_result | (src1 >> sh);
      if (alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(src1) >>> sh);
      if (alu_op[ALU_LUI])  alu_result = alu_result | src2;
   end

   // Low address bits are used as given; misalignment is the decoder's problem
   always_comb begin
      st_we    = 4'b0000;
      st_wdata = st_data;
      case (st_type)
         ST_BYTE: begin
            st_we    = 4'b0001 << sum[1:0];
            st_wdata = {4{st_data[7:0]}};
         end
         ST_HALF: begin
            st_we    = sum[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         ST_WORD: st_we = 4'b1111;
         default: st_we = 4'b0000;
      endcase
   end

   div_radix2 u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (es_valid && div_op[DIV_EN]),
      .is_signed (div_op[DIV_SIGNED]),
      .dividend  (src1),
      .divisor   (src2),
      .ack       (ms_allow_in),
      .busy      (es_div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign es_data_sram_we    = es_valid ? st_we : 4'b0000;
   assign es_data_sram_addr  = sum;
   assign es_data_sram_wdata = st_wdata;
   assign es_rf_we           = {4{gr_we}};
   assign es_rf_waddr        = dest;
   assign es_rf_wdata        = div_op[DIV_EN] ? (div_op[DIV_REM] ? div_rem : div_quo) : alu_result;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_to_es_valid;
   logic        es_allow_in;
   logic        ms_allow_in;
   logic        es_to_ms_valid;
   logic [31:0] ds_pc;
   logic [11:0] ds_alu_op;
   logic [2:0]  ds_div_op;
   logic [31:0] ds_src1;
   logic [31:0] ds_src2;
   logic [1:0]  ds_st_type;
   logic [31:0] ds_st_data;
   logic        ds_gr_we;
   logic [4:0]  ds_dest;
   logic [31:0] es_pc;
   logic [3:0]  es_data_sram_we;
   logic [31:0] es_data_sram_addr;
   logic [31:0] es_data_sram_wdata;
   logic [3:0]  es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_rf_wdata;
   logic        es_valid;
   logic        es_div_busy;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc;
   logic [31:0] cur_pc = 32'h1c00_0000;
   logic [31:0] last_exp;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   localparam logic [2:0] D_U  = 3'b100;
   localparam logic [2:0] D_S  = 3'b110;
   localparam logic [2:0] D_SR = 3'b111;
   localparam logic [2:0] D_UR = 3'b101;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk                (clk),
      .reset              (reset),
      .ds_to_es_valid     (ds_to_es_valid),
      .es_allow_in        (es_allow_in),
      .ms_allow_in        (ms_allow_in),
      .es_to_ms_valid     (es_to_ms_valid),
      .ds_pc              (ds_pc),
      .ds_alu_op          (ds_alu_op),
      .ds_div_op          (ds_div_op),
      .ds_src1            (ds_src1),
      .ds_src2            (ds_src2),
      .ds_st_type         (ds_st_type),
      .ds_st_data         (ds_st_data),
      .ds_gr_we           (ds_gr_we),
      .ds_dest            (ds_dest),
      .es_pc              (es_pc),
      .es_data_sram_we    (es_data_sram_we),
      .es_data_sram_addr  (es_data_sram_addr),
      .es_data_sram_wdata (es_data_sram_wdata),
      .es_rf_we           (es_rf_we),
      .es_rf_waddr        (es_rf_waddr),
      .es_rf_wdata        (es_rf_wdata),
      .es_valid           (es_valid),
      .es_div_busy        (es_div_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Load one instruction; returns #1 after the load edge (cycle 1 in stage)
   task automatic issue(input logic [11:0] alu, input logic [2:0] dop,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] st, input logic [31:0] sd,
                        input string tag, input logic [31:0] exp_w);
      @(negedge clk);
      cur_pc         = cur_pc + 32'd4;
      ds_pc          = cur_pc;
      ds_alu_op      = alu;
      ds_div_op      = dop;
      ds_src1        = a;
      ds_src2        = b;
      ds_st_type     = st;
      ds_st_data     = sd;
      ds_gr_we       = 1'b1;
      ds_dest        = 5'd7;
      ds_to_es_valid = 1'b1;
      exp_q.push_back(exp_w);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      ds_to_es_valid = 1'b0;
   endtask

   // Cycle count starts at 1 in the first cycle after the load edge
   task automatic wait_result(input int budget, output int n);
      n = 1;
      while (es_to_ms_valid !== 1'b1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("out_valid", {31'd0, es_to_ms_valid}, 32'd1);
      if (es_to_ms_valid === 1'b1 && exp_q.size() > 0) begin
         last_exp = exp_q.pop_front();
         check(tag_q.pop_front(), es_rf_wdata, last_exp);
      end
   endtask

   task automatic xfer();
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input logic [31:0] exp_w);
      issue(12'(1) << idx, 3'b000, a, b, ST_NONE, 32'd0, tag, exp_w);
      wait_result(4, cyc);
      check({tag, "_lat"}, cyc, 32'd1);
      xfer();
   endtask

   task automatic run_div(input logic [2:0] dop, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input logic [31:0] exp_w);
      issue(12'd0, dop, a, b, ST_NONE, 32'd0, tag, exp_w);
      wait_result(40, cyc);
      check({tag, "_lat"}, cyc, 32'd34);
      xfer();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      ds_to_es_valid = 1'b0;
      ms_allow_in    = 1'b1;
      ds_pc          = 32'd0;
      ds_alu_op      = 12'd0;
      ds_div_op      = 3'd0;
      ds_src1        = 32'd0;
      ds_src2        = 32'd0;
      ds_st_type     = 2'd0;
      ds_st_data     = 32'd0;
      ds_gr_we       = 1'b0;
      ds_dest        = 5'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pc", es_pc, 32'h1c00_0000);
      check("rst_valid", {31'd0, es_valid}, 32'd0);
      check("rst_allow", {31'd0, es_allow_in}, 32'd1);
      check("rst_tomsv", {31'd0, es_to_ms_valid}, 32'd0);
      check("rst_we", {28'd0, es_data_sram_we}, 32'd0);
      check("rst_wdata", es_rf_wdata, 32'd0);
      check("rst_busy", {31'd0, es_div_busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // add wraps modulo 2^32
      issue(12'(1) << ALU_ADD, 3'b000, 32'd5, 32'hFFFF_FFFF, ST_NONE, 32'd0, "add", 32'd4);
      check("add_allow", {31'd0, es_allow_in}, 32'd1);
      check("add_pc", es_pc, cur_pc);
      check("add_rfwe", {28'd0, es_rf_we}, 32'hF);
      check("add_waddr", {27'd0, es_rf_waddr}, 32'd7);
      wait_result(4, cyc);
      check("add_lat", cyc, 32'd1);
      xfer();
      check("add_gone", {31'd0, es_valid}, 32'd0);

      run_alu(ALU_SUB,  32'd3,         32'd5,         "sub",  32'hFFFF_FFFE);
      run_alu(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         "slt",  32'd1);
      run_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         "sltu", 32'd0);
      run_alu(ALU_AND,  32'hF0F0_1234, 32'hFF00_FF00, "and",  32'hF000_1200);
      run_alu(ALU_NOR,  32'h0F0F_0000, 32'h0000_00FF, "nor",  32'hF0F0_FF00);
      run_alu(ALU_OR,   32'h1200_0000, 32'h0000_0034, "or",   32'h1200_0034);
      run_alu(ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, "xor",  32'hF0F0_0F0F);
      run_alu(ALU_SLL,  32'd1,         32'h21,        "sll",  32'd2);
      run_alu(ALU_SRL,  32'h8000_0000, 32'd4,         "srl",  32'h0800_0000);
      run_alu(ALU_SRA,  32'h8000_0000, 32'd4,         "sra",  32'hF800_0000);
      run_alu(ALU_LUI,  32'd0,         32'hABCD_0000, "lui",  32'hABCD_0000);

      // Byte store at lane 3, then with es_valid low
      issue(12'(1) << ALU_ADD, 3'b000, 32'h100, 32'd3, ST_BYTE, 32'hAB, "sb", 32'h103);
      check("sb_we", {28'd0, es_data_sram_we}, 32'h8);
      check("sb_addr", es_data_sram_addr, 32'h103);
      check("sb_wdata", es_data_sram_wdata, 32'hABAB_ABAB);
      wait_result(4, cyc);
      xfer();
      check("sb_idle_valid", {31'd0, es_valid}, 32'd0);
      check("sb_idle_we", {28'd0, es_data_sram_we}, 32'h0);

      issue(12'(1) << ALU_ADD, 3'b000, 32'h100, 32'd1, ST_BYTE, 32'h5C, "sb1", 32'h101);
      check("sb1_we", {28'd0, es_data_sram_we}, 32'h2);
      wait_result(4, cyc);
      xfer();

      issue(12'(1) << ALU_ADD, 3'b000, 32'h200, 32'd2, ST_HALF, 32'h9999_1234, "sh_hi", 32'h202);
      check("sh_hi_we", {28'd0, es_data_sram_we}, 32'hC);
      check("sh_hi_wdata", es_data_sram_wdata, 32'h1234_1234);
      wait_result(4, cyc);
      xfer();

      issue(12'(1) << ALU_ADD, 3'b000, 32'h200, 32'd0, ST_HALF, 32'h0000_BEEF, "sh_lo", 32'h200);
      check("sh_lo_we", {28'd0, es_data_sram_we}, 32'h3);
      wait_result(4, cyc);
      xfer();

      issue(12'(1) << ALU_ADD, 3'b000, 32'h300, 32'd4, ST_WORD, 32'hDEAD_BEEF, "sw", 32'h304);
      check("sw_we", {28'd0, es_data_sram_we}, 32'hF);
      check("sw_wdata", es_data_sram_wdata, 32'hDEAD_BEEF);
      wait_result(4, cyc);
      xfer();

      // Divides
      run_div(D_S,  32'hFFFF_FFF9, 32'd2,         "sdiv_m7_2",  32'hFFFF_FFFD);
      run_div(D_SR, 32'hFFFF_FFF9, 32'd2,         "srem_m7_2",  32'hFFFF_FFFF);
      run_div(D_U,  32'd100,       32'd7,         "udiv",       32'd14);
      run_div(D_UR, 32'd100,       32'd7,         "urem",       32'd2);
      run_div(D_U,  32'd9,         32'd0,         "div0_q",     32'hFFFF_FFFF);
      run_div(D_UR, 32'd9,         32'd0,         "div0_r",     32'd9);
      run_div(D_SR, 32'hFFFF_FFF7, 32'd0,         "sdiv0_r",    32'hFFFF_FFF7);
      run_div(D_S,  32'h8000_0000, 32'hFFFF_FFFF, "ovf_q",      32'h8000_0000);
      run_div(D_SR, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_r",      32'd0);
      run_div(D_SR, 32'd7,         32'hFFFF_FFFE, "srem_7_m2",  32'd1);

      // Result held while the memory stage stalls
      ms_allow_in = 1'b0;
      issue(12'd0, D_U, 32'd1000, 32'd33, ST_NONE, 32'd0, "stall_q", 32'd30);
      wait_result(40, cyc);
      check("stall_lat", cyc, 32'd34);
      for (int i = 0; i < 5; i++) begin
         xfer();
         check("stall_hold", es_rf_wdata, last_exp);
         check("stall_allow", {31'd0, es_allow_in}, 32'd0);
         check("stall_tomsv", {31'd0, es_to_ms_valid}, 32'd1);
      end
      @(negedge clk);
      ms_allow_in = 1'b1;
      #1;
      check("stall_release", {31'd0, es_allow_in}, 32'd1);
      xfer();
      check("stall_gone", {31'd0, es_valid}, 32'd0);
      check("stall_idle", {31'd0, es_div_busy}, 32'd0);

      // Back-to-back: second loads on the edge the first leaves
      issue(12'd0, D_U, 32'd50, 32'd5, ST_NONE, 32'd0, "b2b_a", 32'd10);
      wait_result(40, cyc);
      check("b2b_a_lat", cyc, 32'd34);
      issue(12'd0, D_UR, 32'd53, 32'd5, ST_NONE, 32'd0, "b2b_b", 32'd3);
      wait_result(40, cyc);
      check("b2b_b_lat", cyc, 32'd34);
      xfer();

      // Asynchronous reset at CALC cycle 10
      issue(12'd0, D_S, 32'd1234, 32'd11, ST_WORD, 32'h1111_1111, "killed", 32'd112);
      repeat (10) @(posedge clk);
      #2;
      check("calc_busy", {31'd0, es_div_busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("ar_pc", es_pc, 32'h1c00_0000);
      check("ar_valid", {31'd0, es_valid}, 32'd0);
      check("ar_busy", {31'd0, es_div_busy}, 32'd0);
      check("ar_tomsv", {31'd0, es_to_ms_valid}, 32'd0);
      check("ar_allow", {31'd0, es_allow_in}, 32'd1);
      check("ar_wdata", es_rf_wdata, 32'd0);
      check("ar_addr", es_data_sram_addr, 32'd0);
      check("ar_sdata", es_data_sram_wdata, 32'd0);
      check("ar_we", {28'd0, es_data_sram_we}, 32'd0);
      check("ar_rfwe", {28'd0, es_rf_we}, 32'd0);
      check("ar_waddr", {27'd0, es_rf_waddr}, 32'd0);
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      reset = 1'b1;
      run_div(D_S, 32'hFFFF_FC18, 32'd7, "post_rst", 32'hFFFF_FF72);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
